// File: rtl/lcd_spi_seq.sv
// Sonata LCD sequencer and mode-0 SPI master: power-on reset, byte framing, timed delays.
// Optional LCD_SPI_SEQ_BYTE_COUNT_EN adds a 16-bit count of completed bytes (byte_count_o).
module lcd_spi_seq #(
  parameter int unsigned ClkDivHalf       = 2,
  parameter int unsigned DelayUnit        = 50000,
  parameter int unsigned RstPulseCycles   = 500,
  parameter int unsigned RstRecoverCycles = 6000000
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [7:0]  req_data_i,
  input  logic        req_last_i,
  output logic        busy_o,
  output logic        lcd_rst_o,
  output logic        lcd_cs_o,
  output logic        lcd_dc_o,
  output logic        lcd_clk_o,
  output logic        lcd_copi_o
`ifdef LCD_SPI_SEQ_BYTE_COUNT_EN
  ,
  output logic [15:0] byte_count_o
`endif
);

  localparam int unsigned CntW = 40;

  typedef enum logic [2:0] {
    RST_LOW,
    RST_WAIT,
    IDLE,
    SHIFT,
    DELAY
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        half_q, half_d;
  logic [7:0]        sr_q, sr_d;
  logic              last_q, last_d;
  logic              rst_q, rst_d;
  logic              cs_q, cs_d;
  logic              dc_q, dc_d;
  logic              sck_q, sck_d;
  logic              copi_q, copi_d;
  logic [CntW-1:0]   delay_prod;
  logic [CntW-1:0]   delay_load;
`ifdef LCD_SPI_SEQ_BYTE_COUNT_EN
  logic [15:0]       bcnt_q, bcnt_d;
`endif

  // 8-bit count times a 32-bit unit always fits in 40 bits; zero still costs one cycle.
  assign delay_prod = CntW'(req_data_i) * CntW'(DelayUnit);
  assign delay_load = (delay_prod == '0) ? CntW'(1) : delay_prod;

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      state_q <= RST_LOW;
      cnt_q   <= '0;
      half_q  <= '0;
      sr_q    <= '0;
      last_q  <= 1'b0;
      rst_q   <= 1'b0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b0;
      sck_q   <= 1'b0;
      copi_q  <= 1'b0;
`ifdef LCD_SPI_SEQ_BYTE_COUNT_EN
      bcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      sr_q    <= sr_d;
      last_q  <= last_d;
      rst_q   <= rst_d;
      cs_q    <= cs_d;
      dc_q    <= dc_d;
      sck_q   <= sck_d;
      copi_q  <= copi_d;
`ifdef LCD_SPI_SEQ_BYTE_COUNT_EN
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    sr_d    = sr_q;
    last_d  = last_q;
    rst_d   = rst_q;
    cs_d    = cs_q;
    dc_d    = dc_q;
    sck_d   = sck_q;
    copi_d  = copi_q;
`ifdef LCD_SPI_SEQ_BYTE_COUNT_EN
    bcnt_d  = bcnt_q;
`endif
    unique case (state_q)
      RST_LOW: begin
        rst_d = 1'b0;
        if (cnt_q == CntW'(RstPulseCycles - 1)) begin
          state_d = RST_WAIT;
          cnt_d   = '0;
          rst_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RST_WAIT: begin
        if (cnt_q == CntW'(RstRecoverCycles - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      IDLE: begin
        if (req_valid_i) begin
          if (!req_op_i[1]) begin
            state_d = SHIFT;
            cnt_d   = '0;
            half_d  = '0;
            sr_d    = req_data_i;
            last_d  = req_last_i;
            cs_d    = 1'b0;
            dc_d    = req_op_i[0];
            copi_d  = req_data_i[7];
            sck_d   = 1'b0;
          end else if (!req_op_i[0]) begin
            state_d = DELAY;
            cnt_d   = delay_load;
          end else begin
            state_d = RST_LOW;
            cnt_d   = '0;
            cs_d    = 1'b1;
            rst_d   = 1'b0;
          end
        end
      end
      SHIFT: begin
        // cnt_q divides the system clock; half_q counts completed SCK half-periods.
        if (cnt_q == CntW'(ClkDivHalf - 1)) begin
          cnt_d  = '0;
          half_d = half_q + 4'd1;
          if (!half_q[0]) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (half_q == 4'd15) begin
              state_d = IDLE;
              cs_d    = last_q;
`ifdef LCD_SPI_SEQ_BYTE_COUNT_EN
              bcnt_d  = bcnt_q + 16'd1;
`endif
            end else begin
              copi_d = sr_q[6];
              sr_d   = {sr_q[6:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DELAY: begin
        if (cnt_q == CntW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = RST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    busy_o      = (state_q != IDLE);
    lcd_rst_o   = rst_q;
    lcd_cs_o    = cs_q;
    lcd_dc_o    = dc_q;
    lcd_clk_o   = sck_q;
    lcd_copi_o  = copi_q;
`ifdef LCD_SPI_SEQ_BYTE_COUNT_EN
    byte_count_o = bcnt_q;
`endif
  end

endmodule
